pwm_color_decoder: RTL and testbench

PWM_COLOR_DECODER -- requirements
Module: pwm_color_decoder

---
 rtl/pwm_color_decoder.sv | 167 ++++++++++++++++
 tb/tb_pwm_color_decoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_color_decoder.sv
// -----------------------------------------------------------------------------
// pwm_color_decoder
//   Recovers an RGB color from three 256-sample PWM channels. Each channel's
//   high samples are counted over one PWM period (delimited by frame_i on the
//   last sample) and the saturated 8-bit counts are published as color_o with
//   a valid/ready handshake. Framing, overrun and (optionally) waveform-shape
//   problems are reported through sticky error flags.
//
// Parameters
//   CHECK_SHAPE : 1 = flag non single-pulse channel waveforms, 0 = no check
//
// Ports
//   clk_i    in   1  system clock, rising edge
//   rst_i    in   1  asynchronous active-high reset
//   pwm_i    in   3  PWM samples {R, G, B}
//   frame_i  in   1  high on the 256th sample of each period
//   ready_i  in   1  consumer takes color_o when valid_o && ready_i
//   clr_i    in   1  synchronous clear of err_o
//   color_o  out 24  {R, G, B} decoded color
//   valid_o  out  1  color_o holds an unconsumed result
//   err_o    out  3  sticky {overrun, shape, frame length}
// -----------------------------------------------------------------------------
module pwm_color_decoder #(
  parameter int CHECK_SHAPE = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  pwm_i,
  input  logic        frame_i,
  input  logic        ready_i,
  input  logic        clr_i,
  output logic [23:0] color_o,
  output logic        valid_o,
  output logic [2:0]  err_o
);

  typedef enum logic {
    ST_SYNC    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  state_t           r_state;
  logic [7:0]       r_pos;
  logic [2:0][8:0]  r_cnt;
  logic [2:0]       r_prev;   // previous sample per channel
  logic [2:0]       r_fell;   // channel has gone 1->0 in this frame

  logic [2:0][8:0]  w_cnt_next;
  logic [2:0][7:0]  w_sat;
  logic [2:0]       w_full;
  logic [2:0]       w_fall;
  logic [2:0]       w_rise;
  logic             w_meas;
  logic             w_at_end;
  logic             w_complete;
  logic             w_early;
  logic             w_lost;
  logic             w_overrun;
  logic             w_shape;
  logic [2:0]       w_err_set;

  // Per-channel counts including the current sample, saturation and edges
  always_comb begin
    w_cnt_next = '0;
    w_sat      = '0;
    w_full     = 3'b000;
    for (int c = 0; c < 3; c++) begin
      w_cnt_next[c] = r_cnt[c] + {8'd0, pwm_i[c]};
      if (w_cnt_next[c][8]) begin
        w_sat[c] = 8'hFF;
      end else begin
        w_sat[c] = w_cnt_next[c][7:0];
      end
      w_full[c] = (w_cnt_next[c] == 9'd256);
    end
    // Edges are only meaningful inside a frame; the boundary between the
    // last sample of one period and the first of the next is not a transition.
    if (r_pos != 8'd0) begin
      w_fall = r_prev & ~pwm_i;
      w_rise = ~r_prev & pwm_i & r_fell;
    end else begin
      w_fall = 3'b000;
      w_rise = 3'b000;
    end
  end

  // Frame classification and error detection for the current cycle
  always_comb begin
    w_meas     = (r_state == ST_MEASURE);
    w_at_end   = (r_pos == 8'd255);
    w_complete = w_meas & frame_i & w_at_end;
    w_early    = w_meas & frame_i & ~w_at_end;
    w_lost     = w_meas & ~frame_i & w_at_end;
    w_overrun  = w_complete & valid_o & ~ready_i;
    if ((CHECK_SHAPE != 0) && w_meas) begin
      w_shape = (|w_rise) | (w_complete & (|w_full));
    end else begin
      w_shape = 1'b0;
    end
    w_err_set = {w_overrun, w_shape, w_early | w_lost};
  end

  // Sequencer, counters, result register, handshake and sticky errors
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_SYNC;
      r_pos   <= 8'd0;
      r_cnt   <= '0;
      r_prev  <= 3'b000;
      r_fell  <= 3'b000;
      color_o <= 24'h000000;
      valid_o <= 1'b0;
      err_o   <= 3'b000;
    end else begin
      r_prev <= pwm_i;
      // New errors win over a simultaneous clear
      if (clr_i) begin
        err_o <= w_err_set;
      end else begin
        err_o <= err_o | w_err_set;
      end

      if (w_complete) begin
        color_o <= {w_sat[2], w_sat[1], w_sat[0]};
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end else begin
        valid_o <= valid_o;
      end

      case (r_state)
        ST_SYNC: begin
          if (frame_i) begin
            r_state <= ST_MEASURE;
            r_pos   <= 8'd0;
            r_cnt   <= '0;
            r_fell  <= 3'b000;
          end else begin
            r_state <= ST_SYNC;
          end
        end
        ST_MEASURE: begin
          if (frame_i || w_at_end) begin
            // Completed, early or missing frame end: restart counting; only
            // a missing end loses alignment.
            r_state <= (frame_i) ? ST_MEASURE : ST_SYNC;
            r_pos   <= 8'd0;
            r_cnt   <= '0;
            r_fell  <= 3'b000;
          end else begin
            r_pos  <= r_pos + 8'd1;
            r_cnt  <= w_cnt_next;
            r_fell <= r_fell | w_fall;
          end
        end
        default: begin
          r_state <= ST_SYNC;
          r_pos   <= 8'd0;
          r_cnt   <= '0;
          r_fell  <= 3'b000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_color_decoder.sv
module tb_pwm_color_decoder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [2:0]  pwm_i;
  logic        frame_i;
  logic        ready_i;
  logic        clr_i;
  logic [23:0] color_s;
  logic        valid_s;
  logic [2:0]  err_s;
  logic [23:0] color_ns;
  logic        valid_ns;
  logic [2:0]  err_ns;

  pwm_color_decoder #(.CHECK_SHAPE(1)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .pwm_i(pwm_i), .frame_i(frame_i),
    .ready_i(ready_i), .clr_i(clr_i),
    .color_o(color_s), .valid_o(valid_s), .err_o(err_s)
  );

  pwm_color_decoder #(.CHECK_SHAPE(0)) u_dut_ns (
    .clk_i(clk_i), .rst_i(rst_i), .pwm_i(pwm_i), .frame_i(frame_i),
    .ready_i(ready_i), .clr_i(clr_i),
    .color_o(color_ns), .valid_o(valid_ns), .err_o(err_ns)
  );

  always #5 clk_i = ~clk_i;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [2:0]  pat [256];
  logic [23:0] q_exp [$];

  typedef struct {
    int          dr;
    int          dg;
    int          db;
    logic [23:0] color;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: apply inputs, let the edge happen, settle 1 time unit after it
  task automatic drive_cycle(input logic [2:0] pwm, input logic frame, input logic clr);
    pwm_i   = pwm;
    frame_i = frame;
    clr_i   = clr;
    @(posedge clk_i);
    #1;
  endtask

  task automatic fill_duty(input int dr, input int dg, input int db);
    for (int p = 0; p < 256; p++) begin
      pat[p] = {(p < dr), (p < dg), (p < db)};
    end
  endtask

  // Drive one aligned 256-sample period from pat; model the expected color
  task automatic run_frame(input logic clr_last, input logic exp_res);
    int cr = 0;
    int cg = 0;
    int cb = 0;
    for (int p = 0; p < 256; p++) begin
      cr += int'(pat[p][2]);
      cg += int'(pat[p][1]);
      cb += int'(pat[p][0]);
    end
    if (cr > 255) cr = 255;
    if (cg > 255) cg = 255;
    if (cb > 255) cb = 255;
    if (exp_res) q_exp.push_back({8'(cr), 8'(cg), 8'(cb)});
    for (int p = 0; p < 256; p++) begin
      drive_cycle(pat[p], (p == 255), clr_last && (p == 255));
    end
    frame_i = 1'b0;
    clr_i   = 1'b0;
  endtask

  // Compare the produced result against the oldest expected entry
  task automatic check_sb(input string name);
    logic [23:0] e;
    if (!valid_s) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: valid_o=0, expected 1", name);
    end else if (q_exp.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: unexpected result %h", name, color_s);
    end else begin
      e = q_exp.pop_front();
      chk({name, "_color"}, 32'(color_s), 32'(e));
      chk({name, "_color_ns"}, 32'(color_ns), 32'(e));
    end
  endtask

  initial begin
    vecs[0] = '{128, 64, 255, 24'h8040FF};
    vecs[1] = '{0, 0, 0, 24'h000000};
    vecs[2] = '{255, 255, 255, 24'hFFFFFF};
    vecs[3] = '{1, 2, 3, 24'h010203};
    vecs[4] = '{200, 17, 99, 24'hC81163};

    rst_i   = 1'b1;
    pwm_i   = 3'b000;
    frame_i = 1'b0;
    ready_i = 1'b1;
    clr_i   = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_color", 32'(color_s), 32'h0);
    chk("rst_valid", 32'(valid_s), 32'h0);
    chk("rst_err", 32'(err_s), 32'h0);
    rst_i = 1'b0;

    // Synchronizing strobe; pwm_i is ignored while syncing
    drive_cycle(3'b111, 1'b1, 1'b0);
    chk("sync_no_valid", 32'(valid_s), 32'h0);

    // Back-to-back duty-cycle frames
    for (int i = 0; i < 5; i++) begin
      fill_duty(vecs[i].dr, vecs[i].dg, vecs[i].db);
      run_frame(1'b0, 1'b1);
      check_sb($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_tbl", i), 32'(color_s), 32'(vecs[i].color));
      chk($sformatf("vec%0d_err", i), 32'(err_s), 32'h0);
    end

    // Shape: R high 10, low 10, high 5
    for (int p = 0; p < 256; p++) begin
      pat[p] = {((p < 10) || (p >= 20 && p < 25)), 1'b0, 1'b0};
    end
    run_frame(1'b0, 1'b1);
    check_sb("shape");
    chk("shape_r", 32'(color_s[23:16]), 32'h0F);
    chk("shape_err", 32'(err_s), 32'b010);
    chk("shape_err_ns", 32'(err_ns), 32'b000);

    // All channels high for 256 samples: saturate, shape error beats clear
    fill_duty(256, 256, 256);
    run_frame(1'b1, 1'b1);
    check_sb("full");
    chk("full_err", 32'(err_s), 32'b010);
    chk("full_err_ns", 32'(err_ns), 32'b000);

    fill_duty(5, 5, 5);
    run_frame(1'b1, 1'b1);
    check_sb("clr1");
    chk("clr1_err", 32'(err_s), 32'b000);

    // Overrun with the consumer stalled
    ready_i = 1'b0;
    fill_duty(1, 2, 3);
    run_frame(1'b0, 1'b1);
    check_sb("ovr_a");
    fill_duty(10, 11, 12);
    run_frame(1'b0, 1'b1);
    check_sb("ovr_b");
    chk("ovr_color", 32'(color_s), 32'h0A0B0C);
    chk("ovr_err", 32'(err_s), 32'b100);
    ready_i = 1'b1;
    fill_duty(5, 6, 7);
    run_frame(1'b1, 1'b1);
    check_sb("clr2");
    chk("clr2_err", 32'(err_s), 32'b000);

    // Early frame strobe at pos 100, with a clear in the same cycle
    fill_duty(50, 50, 50);
    for (int p = 0; p < 100; p++) drive_cycle(pat[p], 1'b0, 1'b0);
    drive_cycle(pat[100], 1'b1, 1'b1);
    frame_i = 1'b0;
    clr_i   = 1'b0;
    chk("early_err", 32'(err_s), 32'b001);
    chk("early_valid", 32'(valid_s), 32'h0);
    chk("early_color", 32'(color_s), 32'h050607);
    fill_duty(20, 30, 40);
    run_frame(1'b0, 1'b1);
    check_sb("after_early");

    // Missing frame strobe: error and loss of sync
    for (int p = 0; p < 256; p++) drive_cycle(3'b000, 1'b0, (p == 0));
    chk("lost_err", 32'(err_s), 32'b001);
    chk("lost_valid", 32'(valid_s), 32'h0);
    chk("lost_color", 32'(color_s), 32'h141E28);

    // Resync, then reset at pos 128
    drive_cycle(3'b000, 1'b1, 1'b0);
    for (int p = 0; p < 128; p++) drive_cycle(3'b111, 1'b0, 1'b0);
    pwm_i = 3'b000;
    rst_i = 1'b1;
    #2;
    chk("mid_rst_color", 32'(color_s), 32'h0);
    chk("mid_rst_valid", 32'(valid_s), 32'h0);
    chk("mid_rst_err", 32'(err_s), 32'h0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    fill_duty(9, 9, 9);
    run_frame(1'b0, 1'b0);
    chk("post_rst_sync_valid", 32'(valid_s), 32'h0);
    chk("post_rst_sync_color", 32'(color_s), 32'h0);
    fill_duty(33, 34, 35);
    run_frame(1'b0, 1'b1);
    check_sb("post_rst");
    chk("post_rst_err", 32'(err_s), 32'h0);
    chk("sb_drained", 32'(q_exp.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
